// File: rtl/reg_dump_reader_if.sv
// Beat stream carrying register-file values out of the dump engine.
// The master side owns valid/data/addr/last; the slave side owns ready.
interface reg_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;

    modport master (
        output valid,
        output data,
        output addr,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  addr,
        input  last,
        output ready
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Sequential register-file read-out engine. Walks a wrapping range of
// registers through a spare combinational read port and streams each value
// out as a registered valid/ready beat, one beat per cycle when unstalled.
module reg_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   num_regs,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_bus,
    reg_dump_reader_if.master out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    // A full dump touches every register once; longer requests are clamped.
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(1 << ADDR_W);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [CNT_W-1:0]  remaining_reg, remaining_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              valid_reg, valid_next;
    logic              last_reg, last_next;
    logic              done_reg, done_next;
    logic [CNT_W-1:0]  num_clamped;
    logic              capture;

    assign num_clamped = (num_regs > MAX_COUNT) ? MAX_COUNT : num_regs;

    // State and output registers; every out_* is driven straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            data_reg      <= '0;
            addr_reg      <= '0;
            valid_reg     <= 1'b0;
            last_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            remaining_reg <= remaining_next;
            data_reg      <= data_next;
            addr_reg      <= addr_next;
            valid_reg     <= valid_next;
            last_reg      <= last_next;
            done_reg      <= done_next;
        end
    end

    // Next-state logic: abort beats a same-cycle handshake, and a capture
    // (from LOAD or from a non-final handshake) samples rf_bus at that edge.
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        remaining_next = remaining_reg;
        data_next      = data_reg;
        addr_next      = addr_reg;
        valid_next     = valid_reg;
        last_next      = last_reg;
        done_next      = 1'b0;
        capture        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (num_clamped != '0) begin
                        ptr_next       = start_addr;
                        remaining_next = num_clamped;
                        state_next     = LOAD;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    valid_next = 1'b0;
                    last_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    capture    = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    valid_next = 1'b0;
                    last_next  = 1'b0;
                    state_next = IDLE;
                end else if (valid_reg && out.ready) begin
                    if (last_reg) begin
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (capture) begin
            data_next      = rf_bus;
            addr_next      = ptr_reg;
            valid_next     = 1'b1;
            last_next      = (remaining_reg == CNT_W'(1));
            ptr_next       = ptr_reg + ADDR_W'(1);
            remaining_next = remaining_reg - CNT_W'(1);
        end
    end

    assign rf_ra     = ptr_reg;
    assign out.valid = valid_reg;
    assign out.data  = data_reg;
    assign out.addr  = addr_reg;
    assign out.last  = last_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: a behavioural register file drives
// rf_bus, and each scenario compares collected beats against an expected list
// built from plain address arithmetic over the bench's own register array.
module tb_reg_dump_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  start_addr;
    logic [5:0]  num_regs;
    logic        abort;
    logic [4:0]  rf_ra;
    logic [31:0] rf_bus;
    logic        busy;
    logic        done;

    reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) out_if ();

    reg_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .num_regs   (num_regs),
        .abort      (abort),
        .rf_ra      (rf_ra),
        .rf_bus     (rf_bus),
        .out        (out_if),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file with a combinational read.
    logic [31:0] rf [32];
    assign rf_bus = rf[rf_ra];

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int          at;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    beat_t got[$];
    beat_t exp_q[$];
    wr_t   wr_q[$];

    int vectors;
    int miscompares;
    int done_count;
    int done_at;
    int first_valid;
    int stall_viol;
    bit busy_first;
    bit any_busy;
    bit any_valid;
    bit timed_out;
    logic valid_after_abort;
    logic last_after_abort;

    // Reference model: the beats a dump of n registers from sa must produce.
    task automatic build_expected(input logic [4:0] sa, input logic [5:0] n);
        int m;
        beat_t b;
        exp_q.delete();
        m = (n > 32) ? 32 : int'(n);
        for (int i = 0; i < m; i++) begin
            b.addr = 5'((int'(sa) + i) % 32);
            b.data = rf[b.addr];
            b.last = (i == m - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    endtask

    // Starts one dump and records what comes out (no checking here).
    // mode 0: ready high, 1: ready toggling, 2: random stalls.
    task automatic collect(input logic [4:0] sa, input logic [5:0] n, input int mode,
                           input int abort_after, input int mid_c, input bit skip_wait,
                           input bit abort_with_start);
        bit          prev_stall;
        bit          abort_sent;
        bit          abort_seen;
        bit          r;
        logic [31:0] prev_data;
        logic [4:0]  prev_addr;
        logic        prev_last;
        beat_t       b;
        got.delete();
        done_count = 0; done_at = -1; first_valid = -1; stall_viol = 0;
        busy_first = 0; any_busy = 0; any_valid = 0; timed_out = 1;
        valid_after_abort = 1'b1; last_after_abort = 1'b1;
        prev_stall = 0; abort_sent = 0; abort_seen = 0;
        prev_data = '0; prev_addr = '0; prev_last = 1'b0;
        if (!skip_wait) @(negedge clk);
        start = 1'b1; start_addr = sa; num_regs = n; abort = abort_with_start;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            if (c == 0) busy_first = busy;
            if (busy) any_busy = 1;
            if (out_if.valid) begin
                any_valid = 1;
                if (first_valid < 0) first_valid = c;
            end
            if (done) begin
                done_count++;
                if (done_at < 0) done_at = c;
            end
            if (abort_sent && !abort_seen) begin
                abort_seen = 1;
                valid_after_abort = out_if.valid;
                last_after_abort = out_if.last;
            end
            if (prev_stall && (!out_if.valid || out_if.data !== prev_data ||
                               out_if.addr !== prev_addr || out_if.last !== prev_last))
                stall_viol++;
            if (c >= 1 && !busy && !out_if.valid) begin
                timed_out = 0;
                break;
            end
            if (c == mid_c) begin
                start = 1'b1; start_addr = sa + 5'd17; num_regs = 6'd3;
            end
            if (abort_after >= 0 && !abort_sent && out_if.valid && got.size() == abort_after) begin
                abort = 1'b1; abort_sent = 1;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (c % 2 == 1);
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            out_if.ready = r;
            if (out_if.valid && r && !abort) begin
                b.addr = out_if.addr; b.data = out_if.data; b.last = out_if.last;
                got.push_back(b);
            end
            while (wr_q.size() > 0 && wr_q[0].at == got.size()) begin
                rf[wr_q[0].a] = wr_q[0].d;
                void'(wr_q.pop_front());
            end
            prev_stall = out_if.valid && !r && !abort;
            prev_data = out_if.data; prev_addr = out_if.addr; prev_last = out_if.last;
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_addr = 5'd3; num_regs = 6'd9; abort = 1'b0;
        out_if.ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        vectors++; if (out_if.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_if.valid); end
        vectors++; if (out_if.data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", out_if.data); end
        vectors++; if (out_if.addr !== 5'd0) begin miscompares++; $display("FAIL reset_addr: got %0d expected 0", out_if.addr); end
        vectors++; if (out_if.last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b expected 0", out_if.last); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        vectors++; if (rf_ra !== 5'd0) begin miscompares++; $display("FAIL reset_rf_ra: got %0d expected 0", rf_ra); end
        $display("reset: outputs idle");
    endtask

    task automatic test_full_dump();
        preload();
        build_expected(5'd0, 6'd32);
        collect(5'd0, 6'd32, 0, -1, -1, 0, 0);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL full_timeout: got timeout expected completion"); end
        vectors++; if (busy_first !== 1'b1) begin miscompares++; $display("FAIL full_busy_n1: got %b expected 1", busy_first); end
        vectors++; if (first_valid != 1) begin miscompares++; $display("FAIL full_first_valid: got cycle %0d expected 1", first_valid); end
        vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL full_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL full_beat%0d: got %h expected %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        vectors++; if (done_count != 1 || done_at != 33) begin miscompares++; $display("FAIL full_done: got %0d pulses at %0d expected 1 at 33", done_count, done_at); end
        $display("full dump: %0d beats, done at cycle %0d", got.size(), done_at);
    endtask

    task automatic test_wrap();
        logic [4:0] sa;
        preload();
        build_expected(5'd30, 6'd4);
        collect(5'd30, 6'd4, 0, -1, -1, 0, 0);
        vectors++; if (got.size() != 4) begin miscompares++; $display("FAIL wrap_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL wrap_beat%0d: got %h expected %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        vectors++; if (done_count != 1 || done_at != 5) begin miscompares++; $display("FAIL wrap_done: got %0d pulses at %0d expected 1 at 5", done_count, done_at); end
        sa = 5'($urandom_range(0, 31));
        build_expected(sa, 6'd40);
        collect(sa, 6'd40, 0, -1, -1, 0, 0);
        vectors++; if (got.size() != 32) begin miscompares++; $display("FAIL clamp_count: got %0d expected 32", got.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL clamp_beat%0d: got %h expected %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        $display("wrap: 30+4 and %0d+40 dumps, %0d beats last", sa, got.size());
    endtask

    task automatic test_backpressure();
        preload();
        for (int mode = 1; mode <= 2; mode++) begin
            build_expected(5'd0, 6'd32);
            collect(5'd0, 6'd32, mode, -1, -1, 0, 0);
            vectors++; if (stall_viol != 0) begin miscompares++; $display("FAIL bp%0d_stable: got %0d changes while stalled expected 0", mode, stall_viol); end
            vectors++; if (got.size() != 32 || done_count != 1) begin miscompares++; $display("FAIL bp%0d_count: got %0d beats %0d done expected 32 1", mode, got.size(), done_count); end
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (i >= got.size() || got[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL bp%0d_beat%0d: got %h expected %h", mode, i, (i < got.size()) ? got[i] : '0, exp_q[i]);
                end
            end
            $display("backpressure mode %0d: %0d beats", mode, got.size());
        end
    endtask

    task automatic test_zero_and_ignored_start();
        preload();
        collect(5'd12, 6'd0, 0, -1, -1, 0, 0);
        vectors++; if (done_count != 1 || done_at != 0) begin miscompares++; $display("FAIL zero_done: got %0d pulses at %0d expected 1 at 0", done_count, done_at); end
        vectors++; if (any_valid || any_busy) begin miscompares++; $display("FAIL zero_quiet: got valid %b busy %b expected 0 0", any_valid, any_busy); end
        build_expected(5'd0, 6'd32);
        collect(5'd0, 6'd32, 0, -1, 5, 0, 0);
        vectors++; if (got.size() != 32 || done_count != 1) begin miscompares++; $display("FAIL ign_count: got %0d beats %0d done expected 32 1", got.size(), done_count); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL ign_beat%0d: got %h expected %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        $display("zero length done at %0d; mid-dump start ignored, %0d beats", done_at, got.size());
    endtask

    task automatic test_abort();
        preload();
        build_expected(5'd0, 6'd5);
        collect(5'd0, 6'd32, 0, 5, -1, 0, 0);
        vectors++; if (got.size() != 5) begin miscompares++; $display("FAIL abort_count: got %0d expected 5", got.size()); end
        vectors++; if (valid_after_abort !== 1'b0 || last_after_abort !== 1'b0) begin miscompares++; $display("FAIL abort_drop: got valid %b last %b expected 0 0", valid_after_abort, last_after_abort); end
        vectors++; if (done_count != 0) begin miscompares++; $display("FAIL abort_nodone: got %0d pulses expected 0", done_count); end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (i >= got.size() || got[i].addr !== exp_q[i].addr || got[i].data !== exp_q[i].data) begin
                miscompares++;
                $display("FAIL abort_beat%0d: got %h expected %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        build_expected(5'd7, 6'd6);
        collect(5'd7, 6'd6, 0, -1, -1, 0, 0);
        vectors++; if (got.size() != 6 || done_count != 1) begin miscompares++; $display("FAIL after_abort_count: got %0d beats %0d done expected 6 1", got.size(), done_count); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL after_abort_beat%0d: got %h expected %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        $display("abort after 5 beats, restart at r7: %0d beats", got.size());
    endtask

    task automatic test_reset_mid();
        preload();
        @(negedge clk);
        out_if.ready = 1'b1; start = 1'b1; start_addr = 5'd9; num_regs = 6'd20;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        vectors++; if (out_if.valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_active: got valid %b expected 1", out_if.valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (out_if.valid !== 1'b0 || out_if.last !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid_last: got %b %b expected 0 0", out_if.valid, out_if.last); end
        vectors++; if (out_if.data !== 32'h0 || out_if.addr !== 5'd0) begin miscompares++; $display("FAIL rstmid_data_addr: got %h %0d expected 0 0", out_if.data, out_if.addr); end
        vectors++; if (rf_ra !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rstmid_ra_busy_done: got %0d %b %b expected 0 0 0", rf_ra, busy, done); end
        @(negedge clk);
        vectors++; if (done !== 1'b0 || out_if.valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_after: got done %b valid %b expected 0 0", done, out_if.valid); end
        build_expected(5'd7, 6'd3);
        collect(5'd7, 6'd3, 0, -1, -1, 0, 0);
        vectors++; if (got.size() != 3 || done_count != 1) begin miscompares++; $display("FAIL rstmid_restart: got %0d beats %0d done expected 3 1", got.size(), done_count); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rstmid_beat%0d: got %h expected %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        $display("reset mid-dump: outputs cleared, restart %0d beats", got.size());
    endtask

    task automatic test_coherence();
        wr_t w;
        preload();
        build_expected(5'd0, 6'd32);
        // r20 is rewritten long before its capture edge; r3 only after it was captured.
        exp_q[20].data = 32'hDEAD_BEEF;
        wr_q.delete();
        w.at = 5;  w.a = 5'd3;  w.d = 32'h0BAD_F00D; wr_q.push_back(w);
        w.at = 10; w.a = 5'd20; w.d = 32'hDEAD_BEEF; wr_q.push_back(w);
        collect(5'd0, 6'd32, 0, -1, -1, 0, 0);
        wr_q.delete();
        vectors++; if (got.size() != 32) begin miscompares++; $display("FAIL coh_count: got %0d expected 32", got.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL coh_beat%0d: got %h expected %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        $display("coherence: r3=%h r20=%h", (got.size() > 3) ? got[3].data : 32'h0, (got.size() > 20) ? got[20].data : 32'h0);
    endtask

    task automatic test_back_to_back();
        preload();
        // start together with abort in IDLE: start must win.
        build_expected(5'd25, 6'd3);
        collect(5'd25, 6'd3, 0, -1, -1, 0, 1);
        vectors++; if (got.size() != 3 || done_count != 1) begin miscompares++; $display("FAIL b2b_first: got %0d beats %0d done expected 3 1", got.size(), done_count); end
        // New start issued in the done cycle.
        build_expected(5'd4, 6'd5);
        collect(5'd4, 6'd5, 0, -1, -1, 1, 0);
        vectors++; if (first_valid != 1 || busy_first !== 1'b1) begin miscompares++; $display("FAIL b2b_latency: got valid at %0d busy %b expected 1 1", first_valid, busy_first); end
        vectors++; if (got.size() != 5 || done_count != 1) begin miscompares++; $display("FAIL b2b_second: got %0d beats %0d done expected 5 1", got.size(), done_count); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_beat%0d: got %h expected %h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        $display("back-to-back: second dump %0d beats", got.size());
    endtask

    task automatic test_random();
        logic [4:0] sa;
        logic [5:0] n;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            sa = 5'($urandom_range(0, 31));
            n  = 6'($urandom_range(0, 63));
            build_expected(sa, n);
            collect(sa, n, 2, -1, -1, 0, 0);
            vectors++; if (timed_out || done_count != 1 || stall_viol != 0) begin miscompares++; $display("FAIL rnd%0d_status: got timeout %b done %0d unstable %0d expected 0 1 0", t, timed_out, done_count, stall_viol); end
            vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL rnd%0d_count: got %0d expected %0d", t, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (i >= got.size() || got[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL rnd%0d_beat%0d: got %h expected %h", t, i, (i < got.size()) ? got[i] : '0, exp_q[i]);
                end
            end
            $display("random %0d: start %0d num %0d -> %0d beats", t, sa, n, got.size());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        preload();
        test_reset();
        test_full_dump();
        test_wrap();
        test_backpressure();
        test_zero_and_ignored_start();
        test_abort();
        test_reset_mid();
        test_coherence();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
